// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: shifts a WIDTH-bit operand by a programmable amount,
// one bit position per clock, under a start/done handshake.
module seq_shifter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] OpNone = 2'b00;
    localparam logic [1:0] OpLeft = 2'b01;
    localparam logic [1:0] OpLsr  = 2'b10;
    localparam logic [1:0] OpAsr  = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            OpLeft:  r = {v[WIDTH-2:0], 1'b0};
            OpLsr:   r = {1'b0, v[WIDTH-1:1]};
            OpAsr:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    out_d = in;
                    op_d  = shift;
                    cnt_d = amount;
                    // Nothing to shift: report completion on the very next cycle.
                    if (amount == '0 || shift == OpNone) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                out_d = shift_one(out_q, op_q);
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            op_q    <= OpNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign out  = out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: scoreboard of expected results and
// done latencies, popped and compared when done is observed.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] dout;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    logic [15:0] exp_out_q[$];
    int          exp_lat_q[$];

    typedef struct {
        logic [15:0] din;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    seq_shifter #(
        .WIDTH(16),
        .AMT_W(4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (din),
        .shift (shift),
        .amount(amount),
        .busy  (busy),
        .done  (done),
        .out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // Drive a request, let edge E0 accept it, then count edges from E0.
    task automatic start_op(input logic [15:0] d, input logic [1:0] op, input logic [3:0] amt,
                            input logic [15:0] res, input int lat);
        din    = d;
        shift  = op;
        amount = amt;
        start  = 1'b1;
        exp_out_q.push_back(res);
        exp_lat_q.push_back(lat);
        tick();
        start    = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic wait_done(input string tag);
        int          lat;
        logic [15:0] res;
        while (!done && edge_cnt < 40) tick();
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no done within %0d edges", tag, edge_cnt);
        end
        if (exp_out_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_sb: done seen with empty scoreboard", tag);
        end else begin
            res = exp_out_q.pop_front();
            lat = exp_lat_q.pop_front();
            check({tag, "_out"}, 32'(dout), 32'(res));
            check({tag, "_lat"}, 32'(edge_cnt), 32'(lat));
            check({tag, "_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFDC9, 2'b01, 4'd1,  16'hFB92, 1};
        vecs[1] = '{16'hFDC9, 2'b10, 4'd1,  16'h7EE4, 1};
        vecs[2] = '{16'hFDC9, 2'b11, 4'd1,  16'hFEE4, 1};
        vecs[3] = '{16'hFDC9, 2'b00, 4'd5,  16'hFDC9, 0};
        vecs[4] = '{16'h8000, 2'b11, 4'd4,  16'hF800, 4};
        vecs[5] = '{16'h8000, 2'b10, 4'd15, 16'h0001, 15};
        vecs[6] = '{16'h0001, 2'b01, 4'd15, 16'h8000, 15};
        vecs[7] = '{16'hFDC9, 2'b10, 4'd0,  16'hFDC9, 0};

        rst_n  = 1'b0;
        start  = 1'b0;
        din    = '0;
        shift  = '0;
        amount = '0;
        #1;
        check("rst_out", 32'(dout), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            start_op(vecs[i].din, vecs[i].op, vecs[i].amt, vecs[i].res, vecs[i].lat);
            check($sformatf("v%0d_busy0", i), 32'(busy), 32'(vecs[i].lat != 0));
            wait_done($sformatf("v%0d", i));
            tick();
            check($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_hold", i), 32'(dout), 32'(vecs[i].res));
        end

        // Asynchronous reset with no clock edge; out is 0xFDC9 from the last vector.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(dout), 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();

        // start during SHIFT with a different operand must be ignored.
        start_op(16'h0F0F, 2'b01, 4'd4, 16'hF0F0, 4);
        tick();
        tick();
        din    = 16'hFFFF;
        shift  = 2'b10;
        amount = 4'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign");
        tick();
        check("ign_pulse", 32'(done), 32'd0);
        check("ign_sb", 32'(exp_out_q.size()), 32'd0);

        // Back-to-back: new starts accepted in the DONE cycle.
        start_op(16'h8000, 2'b11, 4'd4, 16'hF800, 4);
        wait_done("b2b_a");
        start_op(16'h0F0F, 2'b01, 4'd4, 16'hF0F0, 4);
        check("b2b_b_busy0", 32'(busy), 32'd1);
        wait_done("b2b_b");
        start_op(16'h1234, 2'b11, 4'd0, 16'h1234, 0);
        wait_done("b2b_c");
        tick();
        check("b2b_pulse", 32'(done), 32'd0);

        // Reset in the middle of a 10-position shift.
        start_op(16'hFDC9, 2'b10, 4'd10, 16'h0000, 0);
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out", 32'(dout), 32'h0);
        check("mid_busy_rst", 32'(busy), 32'd0);
        check("mid_done_rst", 32'(done), 32'd0);
        exp_out_q.delete();
        exp_lat_q.delete();
        tick();
        tick();
        check("mid_nodone", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("mid_idle_done", 32'(done), 32'd0);
        start_op(16'h0004, 2'b10, 4'd2, 16'h0001, 2);
        wait_done("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
